// File: rtl/drive_mode_scheduler.sv
// drive_mode_scheduler
//   Arbitrates the single motor-command path between Bluetooth manual frames,
//   the line-seek pilot and the obstacle-avoid unit. Obstacle avoidance always
//   pre-empts. Otherwise the last Bluetooth mode command picks STOP, MANUAL or
//   AUTO. A link watchdog forces STOP when manual frames stop arriving.
//
// Ports
//   i_clk          system clock, rising edge
//   i_rst          synchronous reset, active-high
//   i_bt_vld       1-cycle strobe, i_bt_data holds a new frame
//   i_bt_data      [19:13] cmd, [12:10] dir, [9:0] speed
//   i_seek_vld     line-seek request valid this cycle
//   i_seek_dir     line-seek direction
//   i_seek_speed   line-seek speed
//   i_obst_det     obstacle present (level)
//   i_avoid_dir    avoidance direction
//   i_avoid_speed  avoidance speed
//   o_motor_dir    granted direction, 0 = halt
//   o_motor_speed  granted speed, saturated at SPEED_MAX
//   o_motor_vld    1-cycle strobe when o_motor_dir/o_motor_speed change
//   o_mode         00 STOP, 01 MANUAL, 10 AUTO, 11 AVOID
//   o_link_lost    sticky watchdog flag, cleared by the next i_bt_vld
//
// state      | meaning
// ST_STOP    | motor halted (0/0)
// ST_MANUAL  | latched Bluetooth dir/speed drive the motor, watchdog running
// ST_AUTO    | line-seek requests drive the motor, held when no request
// ST_AVOID   | avoidance values drive the motor until obstacle clears + hold

module drive_mode_scheduler #(
  parameter int unsigned LINK_TIMEOUT = 50_000_000,
  parameter int unsigned AVOID_HOLD   = 10_000_000,
  parameter logic [9:0]  SPEED_MAX    = 10'd1000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_bt_vld,
  input  logic [19:0] i_bt_data,
  input  logic        i_seek_vld,
  input  logic [2:0]  i_seek_dir,
  input  logic [9:0]  i_seek_speed,
  input  logic        i_obst_det,
  input  logic [2:0]  i_avoid_dir,
  input  logic [9:0]  i_avoid_speed,
  output logic [2:0]  o_motor_dir,
  output logic [9:0]  o_motor_speed,
  output logic        o_motor_vld,
  output logic [1:0]  o_mode,
  output logic        o_link_lost
);

  typedef enum logic [1:0] {
    ST_STOP   = 2'b00,
    ST_MANUAL = 2'b01,
    ST_AUTO   = 2'b10,
    ST_AVOID  = 2'b11
  } state_t;

  localparam int WD_W   = (LINK_TIMEOUT > 1) ? $clog2(LINK_TIMEOUT) : 1;
  localparam int HOLD_W = $clog2(AVOID_HOLD + 1) > 0 ? $clog2(AVOID_HOLD + 1) : 1;
  localparam logic [WD_W-1:0]   WD_LAST  = WD_W'(LINK_TIMEOUT - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(AVOID_HOLD);

  state_t              r_state;
  state_t              r_sel;
  logic [2:0]          r_man_dir;
  logic [9:0]          r_man_speed;
  logic [WD_W-1:0]     r_wd;
  logic [HOLD_W-1:0]   r_hold;
  logic [2:0]          r_motor_dir;
  logic [9:0]          r_motor_speed;
  logic                r_motor_vld;
  logic                r_link_lost;

  logic [6:0]          w_cmd;
  state_t              w_sel_nxt;
  logic [2:0]          w_man_dir_nxt;
  logic [9:0]          w_man_speed_nxt;
  logic                w_wd_fire;
  state_t              w_state_nxt;
  logic [2:0]          w_dir_nxt;
  logic [9:0]          w_speed_nxt;

  function automatic logic [9:0] f_sat(input logic [9:0] s);
    return (s > SPEED_MAX) ? SPEED_MAX : s;
  endfunction

  assign w_cmd = i_bt_data[19:13];

  always_comb begin
    w_sel_nxt       = r_sel;
    w_man_dir_nxt   = r_man_dir;
    w_man_speed_nxt = r_man_speed;
    if (i_bt_vld) begin
      case (w_cmd)
        7'h00: w_sel_nxt = ST_STOP;
        7'h01: begin
          w_sel_nxt       = ST_MANUAL;
          w_man_dir_nxt   = i_bt_data[12:10];
          w_man_speed_nxt = i_bt_data[9:0];
        end
        7'h02: w_sel_nxt = ST_AUTO;
        default: ;
      endcase
    end

    // An obstacle overrides the watchdog; a frame this cycle feeds the link.
    w_wd_fire = (r_state == ST_MANUAL) && !i_bt_vld && !i_obst_det &&
                (r_wd == WD_LAST);

    if (i_obst_det)
      w_state_nxt = ST_AVOID;
    else if ((r_state == ST_AVOID) && (r_hold < HOLD_MAX))
      w_state_nxt = ST_AVOID;
    else if (w_wd_fire)
      w_state_nxt = ST_STOP;
    else
      w_state_nxt = w_sel_nxt;

    // Mux on the next state so mode and motor values move on the same edge.
    w_dir_nxt   = r_motor_dir;
    w_speed_nxt = r_motor_speed;
    case (w_state_nxt)
      ST_STOP: begin
        w_dir_nxt   = 3'd0;
        w_speed_nxt = 10'd0;
      end
      ST_MANUAL: begin
        w_dir_nxt   = w_man_dir_nxt;
        w_speed_nxt = f_sat(w_man_speed_nxt);
      end
      ST_AUTO: begin
        if (i_seek_vld) begin
          w_dir_nxt   = i_seek_dir;
          w_speed_nxt = f_sat(i_seek_speed);
        end
      end
      ST_AVOID: begin
        w_dir_nxt   = i_avoid_dir;
        w_speed_nxt = f_sat(i_avoid_speed);
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= ST_STOP;
      r_sel         <= ST_STOP;
      r_man_dir     <= 3'd0;
      r_man_speed   <= 10'd0;
      r_wd          <= '0;
      r_hold        <= '0;
      r_motor_dir   <= 3'd0;
      r_motor_speed <= 10'd0;
      r_motor_vld   <= 1'b0;
      r_link_lost   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_sel       <= w_wd_fire ? ST_STOP : w_sel_nxt;
      r_man_dir   <= w_man_dir_nxt;
      r_man_speed <= w_man_speed_nxt;

      if ((r_state == ST_MANUAL) && (w_state_nxt == ST_MANUAL) && !i_bt_vld)
        r_wd <= r_wd + 1'b1;
      else
        r_wd <= '0;

      if (i_obst_det)
        r_hold <= '0;
      else if ((r_state == ST_AVOID) && (r_hold < HOLD_MAX))
        r_hold <= r_hold + 1'b1;

      if (w_wd_fire)
        r_link_lost <= 1'b1;
      else if (i_bt_vld)
        r_link_lost <= 1'b0;

      r_motor_dir   <= w_dir_nxt;
      r_motor_speed <= w_speed_nxt;
      r_motor_vld   <= (w_dir_nxt != r_motor_dir) || (w_speed_nxt != r_motor_speed);
    end
  end

  assign o_motor_dir   = r_motor_dir;
  assign o_motor_speed = r_motor_speed;
  assign o_motor_vld   = r_motor_vld;
  assign o_mode        = r_state;
  assign o_link_lost   = r_link_lost;

endmodule
